// File: rtl/mj_s_ff_s_d_bank.sv
// Scannable D flip-flop bank plus its 1/2/4-bit register-primitive wrappers.
// Optional scan path is compiled in only when MJ_FF_SCAN_EN is defined.

module mj_s_ff_s_d_bank #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             sm,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             so
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q;

`ifdef MJ_FF_SCAN_EN
    // Serial shift image: sin enters at bit 0, so leaves from the MSB.
    logic [WIDTH-1:0] shift_nxt;

    if (WIDTH == 1) begin : g_shift_w1
        assign shift_nxt = sin;
    end else begin : g_shift_wn
        assign shift_nxt = {q[WIDTH-2:0], sin};
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            q <= RST_Q;
        end else if (sm) begin
            q <= shift_nxt;
        end else if (en) begin
            q <= din;
        end
    end

    assign so = q[WIDTH-1];
`else
    // Scan inputs are deliberately left dangling in this build.
    logic unused_scan;
    assign unused_scan = sm ^ sin;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            q <= RST_Q;
        end else if (en) begin
            q <= din;
        end
    end

    assign so = 1'b0;
`endif

    assign out = q;

endmodule

// 1-bit scannable register primitive; the parallel input is named in.
module mj_s_ff_s_d (
    input  logic clk,
    input  logic reset_l,
    input  logic in,
    input  logic sm,
    input  logic sin,
    output logic out,
    output logic so
);

    mj_s_ff_s_d_bank #(
        .WIDTH    (1),
        .RESET_VAL(0)
    ) u_bank (
        .clk    (clk),
        .reset_l(reset_l),
        .din    (in),
        .en     (1'b1),
        .sm     (sm),
        .sin    (sin),
        .out    (out),
        .so     (so)
    );

endmodule

module mj_s_ff_s_d_2 (
    input  logic       clk,
    input  logic       reset_l,
    input  logic [1:0] din,
    input  logic       sm,
    input  logic       sin,
    output logic [1:0] out,
    output logic       so
);

    mj_s_ff_s_d_bank #(
        .WIDTH    (2),
        .RESET_VAL(0)
    ) u_bank (
        .clk    (clk),
        .reset_l(reset_l),
        .din    (din),
        .en     (1'b1),
        .sm     (sm),
        .sin    (sin),
        .out    (out),
        .so     (so)
    );

endmodule

module mj_s_ff_s_d_4 (
    input  logic       clk,
    input  logic       reset_l,
    input  logic [3:0] din,
    input  logic       sm,
    input  logic       sin,
    output logic [3:0] out,
    output logic       so
);

    mj_s_ff_s_d_bank #(
        .WIDTH    (4),
        .RESET_VAL(0)
    ) u_bank (
        .clk    (clk),
        .reset_l(reset_l),
        .din    (din),
        .en     (1'b1),
        .sm     (sm),
        .sin    (sin),
        .out    (out),
        .so     (so)
    );

endmodule

// File: tb/tb_mj_s_ff_s_d_bank.sv
// Directed table-driven bench for the flop bank (WIDTH=4, RESET_VAL=4'hA) and its wrappers.
// Expectations switch on MJ_FF_SCAN_EN to match the build under test.

module tb_mj_s_ff_s_d_bank;

    logic       clk = 1'b0;
    logic       reset_l;
    logic [3:0] din;
    logic       en;
    logic       sm;
    logic       sin;
    logic [3:0] out;
    logic       so;

    logic       w_sm;
    logic       w_sin;
    logic       w1_in;
    logic       w1_out;
    logic       w1_so;
    logic [1:0] w2_din;
    logic [1:0] w2_out;
    logic       w2_so;
    logic [3:0] w4_din;
    logic [3:0] w4_out;
    logic       w4_so;

    int vec_cnt = 0;
    int err_cnt = 0;

`ifdef MJ_FF_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    always #5 clk = ~clk;

    mj_s_ff_s_d_bank #(
        .WIDTH    (4),
        .RESET_VAL(4'hA)
    ) dut (
        .clk    (clk),
        .reset_l(reset_l),
        .din    (din),
        .en     (en),
        .sm     (sm),
        .sin    (sin),
        .out    (out),
        .so     (so)
    );

    mj_s_ff_s_d u_w1 (
        .clk(clk), .reset_l(reset_l), .in(w1_in), .sm(w_sm), .sin(w_sin),
        .out(w1_out), .so(w1_so)
    );

    mj_s_ff_s_d_2 u_w2 (
        .clk(clk), .reset_l(reset_l), .din(w2_din), .sm(w_sm), .sin(w_sin),
        .out(w2_out), .so(w2_so)
    );

    mj_s_ff_s_d_4 u_w4 (
        .clk(clk), .reset_l(reset_l), .din(w4_din), .sm(w_sm), .sin(w_sin),
        .out(w4_out), .so(w4_so)
    );

    typedef struct {
        logic       sm;
        logic       en;
        logic       sin;
        logic [3:0] din;
        logic [3:0] out_scan;
        logic       so_scan;
        logic [3:0] out_noscan;
        logic       so_noscan;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        //          sm    en    sin   din    out/so scan   out/so no-scan
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 1'b0, 4'h5, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'hC, 4'hC, 1'b1, 4'hC, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h3, 4'h3, 1'b0, 4'h3, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 1'b0, 4'h3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 1'b0, 4'h3, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 1'b0, 4'h3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 4'hF, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 4'h2, 1'b0, 4'hF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 4'h5, 1'b0, 4'hF, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'hF, 4'hB, 1'b1, 4'hF, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h6, 4'h6, 1'b0, 4'h6, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h6, 4'hD, 1'b1, 4'h6, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'hB, 1'b1, 4'h6, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'hB, 1'b1, 4'h6, 1'b0};

        reset_l = 1'b1;
        din = 4'h0; en = 1'b0; sm = 1'b0; sin = 1'b0;
        w_sm = 1'b0; w_sin = 1'b0; w1_in = 1'b0; w2_din = 2'b00; w4_din = 4'h0;

        // Mid-cycle asynchronous reset, no edge in between.
        #3 reset_l = 1'b0;
        #1;
        check("async_reset_out", out, 4'hA);
        check("async_reset_so", {3'b0, so}, {3'b0, SCAN});
        check("async_reset_w4", w4_out, 4'h0);
        en = 1'b1; din = 4'h7;
        @(posedge clk); #1;
        check("reset_hold_out", out, 4'hA);

        @(negedge clk);
        en = 1'b0;
        reset_l = 1'b1;
        #1;
        check("release_no_edge", out, 4'hA);
        @(posedge clk); #1;
        check("first_edge_hold", out, 4'hA);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            sm = vecs[i].sm; en = vecs[i].en; sin = vecs[i].sin; din = vecs[i].din;
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", i), out, SCAN ? vecs[i].out_scan : vecs[i].out_noscan);
            check($sformatf("vec%0d_so", i), {3'b0, so},
                  {3'b0, SCAN ? vecs[i].so_scan : vecs[i].so_noscan});
        end

        // Control changes between edges must not reach out.
        @(negedge clk);
        sm = 1'b0; en = 1'b1; din = 4'h9;
        #1;
        check("no_comb_path", out, SCAN ? 4'hB : 4'h6);
        en = 1'b0;
        @(posedge clk); #1;
        check("en_sampled_at_edge", out, SCAN ? 4'hB : 4'h6);

        // Wrappers load on every edge.
        @(negedge clk);
        w1_in = 1'b1; w2_din = 2'b10; w4_din = 4'b1001;
        @(posedge clk); #1;
        check("w1_out", {3'b0, w1_out}, 4'h1);
        check("w2_out", {2'b0, w2_out}, 4'h2);
        check("w4_out", w4_out, 4'h9);
        check("w1_so", {3'b0, w1_so}, {3'b0, SCAN});
        check("w2_so", {3'b0, w2_so}, {3'b0, SCAN});
        check("w4_so", {3'b0, w4_so}, {3'b0, SCAN});

        // One-bit shift: sin replaces the bit, so follows out.
        @(negedge clk);
        w_sm = 1'b1; w_sin = 1'b0;
        @(posedge clk); #1;
        check("w1_shift_out", {3'b0, w1_out}, SCAN ? 4'h0 : 4'h1);
        check("w4_shift_out", w4_out, SCAN ? 4'b0010 : 4'b1001);
        check("w1_shift_so", {3'b0, w1_so}, 4'h0);

        // Re-assert reset asynchronously while loading.
        @(negedge clk);
        w_sm = 1'b0;
        reset_l = 1'b0;
        #1;
        check("reassert_out", out, 4'hA);
        check("reassert_w2", {2'b0, w2_out}, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
